// File: rtl/fft_r22_stage.sv
// One R2^2 SDF stage: BF2I, BF2II with -j swap/negate, and a rounded twiddle
// multiplier that is bypassed in the last stage. Output is in natural m order.
module fft_r22_stage #(
  parameter int N             = 1024,
  parameter int STAGE         = 0,
  parameter int WIDTH         = 24,
  parameter int TWIDDLE_WIDTH = 18
) (
  input  logic                            clk,
  input  logic                            arst,
  input  logic                            en_i,
  input  logic [$clog2(N)-1:0]            ctr_i,
  input  logic signed [WIDTH-1:0]         x_re_i,
  input  logic signed [WIDTH-1:0]         x_im_i,
  output logic                            valid_o,
  output logic [$clog2(N)-1:0]            ctr_o,
  output logic signed [WIDTH-1:0]         y_re_o,
  output logic signed [WIDTH-1:0]         y_im_o,
  output logic [$clog2(N)-1:0]            tw_addr_o,
  input  logic signed [TWIDDLE_WIDTH-1:0] w_re_i,
  input  logic signed [TWIDDLE_WIDTH-1:0] w_im_i
);

  localparam int LOGN = $clog2(N);
  localparam int L    = N >> (2 * STAGE);
  localparam int LOGL = $clog2(L);
  localparam bit LAST = (STAGE == LOGN / 2 - 1);
  localparam int P    = LAST ? 2 : 5;
  localparam int D    = 3 * L / 4 + P;
  localparam int TW   = TWIDDLE_WIDTH;
  localparam int PW   = WIDTH + TW + 1;

  logic [1:0]                rst_s;
  logic                      rst;
  logic [LOGN:0]             tag_q [D];
  logic                      a_vld, m_vld;
  logic [LOGL-1:0]           n, na, nm;
  logic signed [WIDTH-1:0]   d1_re [L/2];
  logic signed [WIDTH-1:0]   d1_im [L/2];
  logic signed [WIDTH-1:0]   d2_re [L/4];
  logic signed [WIDTH-1:0]   d2_im [L/4];
  logic signed [WIDTH-1:0]   b1_re, b1_im, f1_re, f1_im;
  logic signed [WIDTH-1:0]   a_re, a_im, ar_re, ar_im;
  logic signed [WIDTH-1:0]   b2_re, b2_im, f2_re, f2_im;
  logic signed [WIDTH-1:0]   c_re, c_im;
  logic                      rot;

  // Reset asserts at once, releases two clocks after arst falls.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) rst_s <= 2'b11;
    else      rst_s <= {rst_s[0], 1'b0};
  end
  assign rst = rst_s[1];

  // Valid/tag pipeline of depth D; intermediate taps time the butterfly controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= {en_i, ctr_i};
      for (int i = 1; i < D; i++) tag_q[i] <= tag_q[i-1];
    end
  end
  assign a_vld   = tag_q[L/2][LOGN];
  assign m_vld   = tag_q[3*L/4+1][LOGN];
  assign valid_o = tag_q[D-1][LOGN];
  assign ctr_o   = tag_q[D-1][LOGN-1:0];

  // Sample index counters for input (n), BF2II input (na) and BF2II output (nm).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n  <= '0;
      na <= '0;
      nm <= '0;
    end else begin
      n  <= en_i  ? n  + LOGL'(1) : '0;
      na <= a_vld ? na + LOGL'(1) : '0;
      nm <= m_vld ? nm + LOGL'(1) : '0;
    end
  end

  // BF2I: first half loads the delay line, second half emits sums and stores differences.
  always_comb begin
    b1_re = d1_re[L/2-1];
    b1_im = d1_im[L/2-1];
    f1_re = x_re_i;
    f1_im = x_im_i;
    if (n[LOGL-1]) begin
      b1_re = d1_re[L/2-1] + x_re_i;
      b1_im = d1_im[L/2-1] + x_im_i;
      f1_re = d1_re[L/2-1] - x_re_i;
      f1_im = d1_im[L/2-1] - x_im_i;
    end
  end

  // BF2I feedback delay line and output register; the delay lines run every cycle to flush.
  always_ff @(posedge clk) begin
    d1_re[0] <= f1_re;
    d1_im[0] <= f1_im;
    for (int i = 1; i < L/2; i++) begin
      d1_re[i] <= d1_re[i-1];
      d1_im[i] <= d1_im[i-1];
    end
    a_re <= b1_re;
    a_im <= b1_im;
  end

  // BF2II: last quarter of the BF2I stream is rotated by -j (swap, negate) before combining.
  assign rot = na[LOGL-1] & na[LOGL-2];
  always_comb begin
    ar_re = rot ? a_im : a_re;
    ar_im = rot ? -a_re : a_im;
    b2_re = d2_re[L/4-1];
    b2_im = d2_im[L/4-1];
    f2_re = ar_re;
    f2_im = ar_im;
    if (na[LOGL-2]) begin
      b2_re = d2_re[L/4-1] + ar_re;
      b2_im = d2_im[L/4-1] + ar_im;
      f2_re = d2_re[L/4-1] - ar_re;
      f2_im = d2_im[L/4-1] - ar_im;
    end
  end

  // BF2II feedback delay line.
  always_ff @(posedge clk) begin
    d2_re[0] <= f2_re;
    d2_im[0] <= f2_im;
    for (int i = 1; i < L/4; i++) begin
      d2_re[i] <= d2_re[i-1];
      d2_im[i] <= d2_im[i-1];
    end
  end

  // BF2II output register; this is the stage output when the multiplier is bypassed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_re <= '0;
      c_im <= '0;
    end else begin
      c_re <= b2_re;
      c_im <= b2_im;
    end
  end

  if (LAST) begin : g_bypass
    assign y_re_o    = c_re;
    assign y_im_o    = c_im;
    assign tw_addr_o = '0;
  end else begin : g_mult
    localparam logic signed [PW-1:0] HALF = PW'(2 ** (TW - 3));
    logic [1:0]              q;
    logic [LOGN-1:0]         kq;
    logic signed [WIDTH-1:0] r3_re, r3_im;
    logic signed [PW-1:0]    p_re, p_im;
    logic signed [WIDTH-1:0] yq_re, yq_im;

    // Address follows the BF2II output; q is bit-reversed to give the 0,2,1,3 multiplier.
    assign q         = nm[LOGL-1:LOGL-2];
    assign kq        = LOGN'(nm[LOGL-3:0]) * LOGN'({q[0], q[1]});
    assign tw_addr_o = kq << (2 * STAGE);

    // Hold the sample for the cycle the ROM takes to answer.
    always_ff @(posedge clk) begin
      r3_re <= c_re;
      r3_im <= c_im;
    end

    // Full-precision complex product.
    always_ff @(posedge clk) begin
      p_re <= PW'(r3_re) * PW'(w_re_i) - PW'(r3_im) * PW'(w_im_i);
      p_im <= PW'(r3_re) * PW'(w_im_i) + PW'(r3_im) * PW'(w_re_i);
    end

    // Round half up, rescale by the twiddle unity, truncate to WIDTH.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        yq_re <= '0;
        yq_im <= '0;
      end else begin
        yq_re <= WIDTH'((p_re + HALF) >>> (TW - 2));
        yq_im <= WIDTH'((p_im + HALF) >>> (TW - 2));
      end
    end
    assign y_re_o = yq_re;
    assign y_im_o = yq_im;
  end

endmodule

// File: tb/tb_fft_r22_stage.sv
// Bench for fft_r22_stage: N=16 stage 0 (multiplier) and stage 1 (bypass),
// scoreboard of expected outputs with their expected arrival cycle.
module tb_fft_r22_stage;

  localparam int W  = 24;
  localparam int TW = 18;
  localparam int D0 = 17;
  localparam int D1 = 5;
  localparam real PI = 3.14159265358979323846;

  typedef struct {
    int re;
    int im;
    int ctr;
    int cyc;
    int addr;
  } exp_t;

  logic clk = 1'b0;
  logic arst = 1'b1;

  logic                 en0, en1;
  logic [3:0]           ctr0, ctr1, co0, co1, ta0, ta1;
  logic signed [W-1:0]  xr0, xi0, xr1, xi1, yr0, yi0, yr1, yi1;
  logic                 v0, v1;
  logic signed [TW-1:0] wr0, wi0, wr1, wi1;

  int rom_re [16];
  int rom_im [16];
  int cyc = 0;
  int tag = 0;
  int n_tests = 0;
  int n_fail = 0;
  int h0 [4];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t em;
  int xa [16];
  int xb [16];

  fft_r22_stage #(.N(16), .STAGE(0), .WIDTH(W), .TWIDDLE_WIDTH(TW)) u0 (
    .clk(clk), .arst(arst), .en_i(en0), .ctr_i(ctr0), .x_re_i(xr0), .x_im_i(xi0),
    .valid_o(v0), .ctr_o(co0), .y_re_o(yr0), .y_im_o(yi0), .tw_addr_o(ta0),
    .w_re_i(wr0), .w_im_i(wi0)
  );

  fft_r22_stage #(.N(16), .STAGE(1), .WIDTH(W), .TWIDDLE_WIDTH(TW)) u1 (
    .clk(clk), .arst(arst), .en_i(en1), .ctr_i(ctr1), .x_re_i(xr1), .x_im_i(xi1),
    .valid_o(v1), .ctr_o(co1), .y_re_o(yr1), .y_im_o(yi1), .tw_addr_o(ta1),
    .w_re_i(wr1), .w_im_i(wi1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Twiddle ROM with one cycle of read latency.
  always @(posedge clk) begin
    wr0 <= TW'(rom_re[ta0]);
    wi0 <= TW'(rom_im[ta0]);
  end

  task automatic chk(input string tag_s, input int obs, input int expv, input int tol);
    n_tests++;
    assert (((obs - expv) <= tol) && ((expv - obs) <= tol)) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag_s, obs, expv);
    end
  endtask

  // Reference butterfly/twiddle in double precision.
  task automatic model(input int L, input bit mult, input int xr[16], input int xi[16],
                       output int yr[16], output int yi[16], output int ad[16]);
    real x0r, x0i, x1r, x1i, x2r, x2i, x3r, x3i, sr, si, ang;
    int e, qn, m;
    for (int i = 0; i < 16; i++) begin
      yr[i] = 0; yi[i] = 0; ad[i] = 0;
    end
    for (int q = 0; q < 4; q++) begin
      for (int k = 0; k < L/4; k++) begin
        x0r = xr[k];       x0i = xi[k];
        x1r = xr[k+L/4];   x1i = xi[k+L/4];
        x2r = xr[k+L/2];   x2i = xi[k+L/2];
        x3r = xr[k+3*L/4]; x3i = xi[k+3*L/4];
        case (q)
          0: begin sr = x0r+x1r+x2r+x3r; si = x0i+x1i+x2i+x3i; e = 0; qn = 0; end
          1: begin sr = (x0r+x2r)-(x1r+x3r); si = (x0i+x2i)-(x1i+x3i); e = 2*k; qn = 2; end
          2: begin sr = (x0r-x2r)+(x1i-x3i); si = (x0i-x2i)-(x1r-x3r); e = k; qn = 1; end
          default: begin sr = (x0r-x2r)-(x1i-x3i); si = (x0i-x2i)+(x1r-x3r); e = 3*k; qn = 3; end
        endcase
        m = q*L/4 + k;
        if (mult) begin
          ang = -2.0 * PI * e / L;
          yr[m] = int'(sr * $cos(ang) - si * $sin(ang));
          yi[m] = int'(sr * $sin(ang) + si * $cos(ang));
        end else begin
          yr[m] = int'(sr);
          yi[m] = int'(si);
        end
        ad[m] = (k * qn) % 16;
      end
    end
  endtask

  task automatic blk0(input int xr[16], input int xi[16]);
    int yr[16], yi[16], ad[16];
    exp_t e;
    model(16, 1'b1, xr, xi, yr, yi, ad);
    for (int m = 0; m < 16; m++) begin
      @(posedge clk); #1;
      en0 = 1'b1; xr0 = W'(xr[m]); xi0 = W'(xi[m]); ctr0 = 4'(tag);
      e.re = yr[m]; e.im = yi[m]; e.ctr = tag & 15; e.cyc = cyc + D0; e.addr = ad[m];
      q0.push_back(e);
      tag++;
    end
  endtask

  task automatic blk1(input int xr[16], input int xi[16]);
    int yr[16], yi[16], ad[16];
    exp_t e;
    model(4, 1'b0, xr, xi, yr, yi, ad);
    for (int m = 0; m < 4; m++) begin
      @(posedge clk); #1;
      en1 = 1'b1; xr1 = W'(xr[m]); xi1 = W'(xi[m]); ctr1 = 4'(tag);
      e.re = yr[m]; e.im = yi[m]; e.ctr = tag & 15; e.cyc = cyc + D1; e.addr = 0;
      q1.push_back(e);
      tag++;
    end
  endtask

  task automatic stop0();
    @(posedge clk); #1;
    en0 = 1'b0;
  endtask

  task automatic stop1();
    @(posedge clk); #1;
    en1 = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while ((q0.size() != 0 || q1.size() != 0) && i < 300) begin
      @(posedge clk);
      i++;
    end
    chk("drain_left", q0.size() + q1.size(), 0, 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic rand_x(input int amp);
    for (int i = 0; i < 16; i++) begin
      xa[i] = int'($urandom_range(2*amp)) - amp;
      xb[i] = int'($urandom_range(2*amp)) - amp;
    end
  endtask

  // Scoreboard: pop and compare whenever a DUT presents a valid sample.
  always @(negedge clk) begin
    h0[3] = h0[2]; h0[2] = h0[1]; h0[1] = h0[0]; h0[0] = int'(ta0);
    if (!arst) begin
      if (v0 === 1'b1) begin
        if (q0.size() == 0) chk("u0_spurious_valid", int'(v0), 0, 0);
        else begin
          em = q0.pop_front();
          chk("u0_re", yr0, em.re, 1);
          chk("u0_im", yi0, em.im, 1);
          chk("u0_ctr", int'(co0), em.ctr, 0);
          chk("u0_cycle", cyc, em.cyc, 0);
          chk("u0_tw_addr", h0[3], em.addr, 0);
        end
      end
      if (v1 === 1'b1) begin
        if (q1.size() == 0) chk("u1_spurious_valid", int'(v1), 0, 0);
        else begin
          em = q1.pop_front();
          chk("u1_re", yr1, em.re, 0);
          chk("u1_im", yi1, em.im, 0);
          chk("u1_ctr", int'(co1), em.ctr, 0);
          chk("u1_cycle", cyc, em.cyc, 0);
        end
      end
    end
  end

  initial begin
    for (int a = 0; a < 16; a++) begin
      rom_re[a] = int'($cos(2.0 * PI * a / 16.0) * 65536.0);
      rom_im[a] = int'(-$sin(2.0 * PI * a / 16.0) * 65536.0);
    end
    for (int i = 0; i < 4; i++) h0[i] = 0;
    en0 = 0; en1 = 0; ctr0 = 0; ctr1 = 0;
    xr0 = 0; xi0 = 0; xr1 = 0; xi1 = 0; wr1 = 0; wi1 = 0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_valid0", int'(v0), 0, 0);
    chk("rst_ctr0", int'(co0), 0, 0);
    chk("rst_yre0", yr0, 0, 0);
    chk("rst_yim0", yi0, 0, 0);
    chk("rst_tw0", int'(ta0), 0, 0);
    chk("rst_valid1", int'(v1), 0, 0);
    chk("rst_yre1", yr1, 0, 0);
    arst = 1'b0;
    repeat (4) @(posedge clk);

    // Radix-4 check on the bypassed stage: 1,2,3,4
    for (int i = 0; i < 16; i++) begin xa[i] = 0; xb[i] = 0; end
    for (int i = 0; i < 4; i++) xa[i] = i + 1;
    blk1(xa, xb);
    stop1();
    drain();

    // Impulse
    for (int i = 0; i < 16; i++) begin xa[i] = 0; xb[i] = 0; end
    xa[0] = 1000;
    blk0(xa, xb);
    stop0();
    drain();

    // DC
    for (int i = 0; i < 16; i++) xa[i] = 100;
    blk0(xa, xb);
    stop0();
    drain();

    // Complex random block: twiddle addresses and rounding
    rand_x(1000);
    blk0(xa, xb);
    stop0();
    drain();

    // Three back-to-back blocks on each stage
    for (int b = 0; b < 3; b++) begin
      rand_x(1000);
      blk0(xa, xb);
    end
    stop0();
    for (int b = 0; b < 3; b++) begin
      rand_x(1000);
      blk1(xa, xb);
    end
    stop1();
    drain();

    // Reset at n=7 of a block while the previous block is streaming out
    rand_x(1000);
    blk0(xa, xb);
    for (int m = 0; m < 7; m++) begin
      @(posedge clk); #1;
      en0 = 1'b1; xr0 = W'(m * 7); xi0 = 0; ctr0 = 4'(m);
    end
    @(posedge clk); #1;
    en0 = 1'b1; xr0 = 5; ctr0 = 4'd7;
    #2;
    chk("pre_rst_valid", int'(v0), 1, 0);
    arst = 1'b1;
    #1;
    chk("async_rst_valid", int'(v0), 0, 0);
    chk("async_rst_ctr", int'(co0), 0, 0);
    chk("async_rst_yre", yr0, 0, 0);
    chk("async_rst_yim", yi0, 0, 0);
    en0 = 1'b0;
    q0.delete();
    repeat (2) @(posedge clk); #1;
    chk("hold_rst_valid", int'(v0), 0, 0);
    arst = 1'b0;
    @(posedge clk); #1;
    chk("sync_rel_valid", int'(v0), 0, 0);
    chk("sync_rel_yre", yr0, 0, 0);
    chk("sync_rel_ctr", int'(co0), 0, 0);
    @(posedge clk); #1;
    chk("sync_rel2_valid", int'(v0), 0, 0);
    rand_x(1000);
    blk0(xa, xb);
    stop0();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_r22_stage.md
# fft_r22_stage

One pipeline stage of a radix-2^2 single-path delay-feedback (R2²SDF) decimation-in-frequency FFT. The stage contains a BF2I butterfly, a BF2II butterfly with trivial −j rotation, and a twiddle multiplier. The multiplier is bypassed in the last stage. log2(N)/2 instances are chained, STAGE = 0, 1, …, to form an N-point FFT. The FFT result leaves the final stage in bit-reversed order.

## Interface
- N, 1024: FFT length; a power of 4, ≥16.
- STAGE, 0: stage index s, 0…log2(N)/2−1. Local span L = N/4^s.
- WIDTH, 24: data width, real and imaginary parts, signed.
- TWIDDLE_WIDTH, 18: twiddle width, signed; 1.0 is encoded as 2^(TWIDDLE_WIDTH−2).

Ports:
- clk  in  1  clock; everything is on the rising edge.
- arst  in  1  asynchronous active-high reset; deassertion is synchronized internally through 2 flops.
- en_i  in  1  input sample valid.
- ctr_i  in  log2(N)  sample tag; passed through aligned with the data.
- x_re_i, x_im_i  in  WIDTH  input sample.
- valid_o  out  1  output sample valid.
- ctr_o  out  log2(N)  ctr_i delayed by the stage latency D.
- y_re_o, y_im_o  out  WIDTH  output sample.
- tw_addr_o  out  log2(N)  twiddle ROM address; unused when the multiplier is bypassed.
- w_re_i, w_im_i  in  TWIDDLE_WIDTH  twiddle W_N^tw_addr_o, returned by the ROM one cycle after the address.

## Operation
- Local counter n (log2(L) bits):
  - cleared while en_i=0;
  - incremented on every cycle with en_i=1;
  - wraps at L.
- Input contract: en_i is held high for whole multiples of L samples.
- Block definition: each L-sample block x[0..L−1] is taken as xi[k] = x[k + i·L/4], k = 0…L/4−1.
- Output order: y is emitted in natural m order, m = q·L/4 + k:
  - q=0: x0+x1+x2+x3
  - q=1: ((x0+x2)−(x1+x3))·W_L^(2k)
  - q=2: ((x0−x2)−j(x1−x3))·W_L^(k)
  - q=3: ((x0−x2)+j(x1−x3))·W_L^(3k)
- Structure:
  - BF2I: delay line L/2, control bit n[log2L−1].
  - BF2II: delay line L/4, control bit n[log2L−2].
  - −j·(a+jb) = b − ja, implemented as swap and negate.
- Twiddle address: tw_addr_o = (k·q_nat·4^s) mod N, with q_nat = 0, 2, 1, 3 for q = 0…3.
- Butterfly add/sub: two's-complement, wraps at WIDTH with no saturation. Headroom is the integrator's responsibility.
- Complex multiply:
  - full-precision products, re = xr·wr − xi·wi, im = xr·wi + xi·wr;
  - add 2^(TWIDDLE_WIDTH−3), then arithmetic shift right by TWIDDLE_WIDTH−2;
  - truncate to WIDTH.
- Last stage (STAGE = log2(N)/2−1): no multiply, all twiddles are 1. tw_addr_o is held 0.
- Reset:
  - During reset, and for 2 clk after deassertion: valid_o=0, ctr_o=0, y_re_o=y_im_o=0, n=0.
  - Delay-line contents are don't-care.
  - Reset mid-block discards the block. The next en_i rising edge starts a new block at n=0.

## Timing
- Pipeline depth:
  - P=5 with the multiplier: BF2I reg, BF2II reg, ROM read, product reg, round reg.
  - P=2 when bypassed.
- Latency:
  - D = 3L/4 + P cycles.
  - y[m] appears D cycles after x[m] was accepted.
  - valid_o = en_i delayed by D; ctr_o = ctr_i delayed by D.
- Continuous operation: back-to-back blocks with en_i never dropping stream with no gaps or bubbles.
- Outputs with valid_o=0 are don't-care except during reset, when they are 0.
- arst assertion forces all outputs to 0 in the same cycle, without waiting for a clock edge.

## Test plan
- Radix-4 check, N=16, STAGE=1 (L=4, bypass, D=5):
  - stimulus x = 1, 2, 3, 4;
  - response y = 10, −2, −2+2j, −2−2j;
  - valid_o rises 5 cycles after en_i.
- Impulse, N=16, STAGE=0 (L=16, D=17):
  - stimulus x[0]=1000, others 0;
  - response y[0] = y[4] = y[8] = y[12] = 1000, all others 0.
- DC, N=16, STAGE=0:
  - stimulus x = 100 for all samples;
  - response y[0..3] = 400, y[4..15] = 0.
- Twiddle address sequence, N=16, STAGE=0:
  - tw_addr_o = 0,0,0,0 | 0,2,4,6 | 0,1,2,3 | 0,3,6,9;
  - ROM model with one-cycle latency;
  - y matches the double-precision reference within ±1 LSB.
- Streaming: 3 back-to-back blocks of random data → continuous valid_o for 3L cycles, each block correct.
- Reset:
  - assert arst at n=7 → valid_o=0 immediately;
  - release arst, restart en_i 3 cycles later → first valid output D cycles after the new start.
